keypad_seq_lock: RTL
====================

// Module: keypad_seq_lock
// PURPOSE
//  Parametrised keypad sequence detector and combination lock, running on hwclk.
//  Takes one-cycle debounced press pulses from NUM_KEYS button instances and detects a SEQ_LEN key pattern.
//  Detection uses a sliding window, so overlapping attempts are found. Adds entry timeout, multi-press rejection and a timed unlock hold.
//  Sits between the button debouncers and the LED/actuator logic in top-level designs.
// PARAMETERS
//  NUM_KEYS       4           number of key inputs (>=2)
//  SEQ_LEN        4           keys in the pattern (>=1)
//  KEY_W          2           key code width, >= $clog2(NUM_KEYS)
//  SEQ_PATTERN    8'b00010001 packed pattern; element i = bits[i*KEY_W +: KEY_W]; element 0 = first key
//                             (default gives key sequence 1,0,1,0 with key codes 0..3)
//  TIMEOUT_CYCLES 12_000_000  idle cycles in ENTRY/PROG before abort (1 s at 12 MHz)
//  HOLD_CYCLES    36_000_000  cycles unlocked stays high after a match
// PORTS
//  hwclk      in   1              system clock, all logic rising-edge
//  rst        in   1              synchronous, active-high reset
//  press      in   NUM_KEYS       one-cycle press pulses, bit k = key k
//  unlocked   out  1              high while in OPEN
//  match      out  1              one-cycle pulse when the pattern completes
//  error      out  1              one-cycle pulse on multi-press or timeout
//  progress   out  $clog2(SEQ_LEN+1)  valid keys in the window, saturates at SEQ_LEN
//  last_key   out  KEY_W          code of the most recent valid press
// BEHAVIOUR
//  Reset: state=IDLE; unlocked=0, match=0, error=0, progress=0, last_key=0; history, timers cleared.
//  Key decode: exactly one press bit set -> valid event, code=index. Zero bits -> no event.
//    Two or more bits set -> multi event.
//  History: on a valid event, hist <= {code, hist[SEQ_LEN*KEY_W-1:KEY_W]}. After SEQ_LEN events, element 0 is the oldest key.
//  Latency: outputs are registered. An event in cycle t updates progress, last_key, match and error in cycle t+1.
//  States:
//   IDLE : progress=0. A valid event goes to ENTRY with fill=1. A multi event pulses error and stays in IDLE.
//   ENTRY: each valid event shifts hist; fill=min(fill+1,SEQ_LEN).
//          Match when fill==SEQ_LEN and the post-shift hist==pattern -> match pulse, clear hist/fill, go to OPEN.
//          A multi event pulses error, clears hist/fill and goes to IDLE.
//          Idle counter resets on any event. At TIMEOUT_CYCLES-1 without an event: error pulse, clear, go to IDLE.
//   OPEN : unlocked=1. Hold counter runs 0..HOLD_CYCLES-1, then goes to IDLE with unlocked=0 the next cycle.
//          Presses are ignored in OPEN; match and error cannot fire.
//  SEQ_LEN==1: a matching valid event from IDLE goes straight to OPEN.
//  Mismatch at full window: no error; the window keeps sliding, so overlapping attempts still match.
//  rst high in any state overrides all else, including mid-entry or mid-hold.
//  Counters are sized $clog2(MAX+1); no wrap is reachable. press bits above the key count do not exist.
// CONFIGURATION
//  KEYPAD_SEQ_PROG_EN defined:
//   - Extra ports: prog_req (in, 1, level) and prog_done (out, 1, pulse).
//   - The pattern is held in a register, loaded from SEQ_PATTERN on reset.
//   - prog_req=1 in IDLE or ENTRY: go to PROG and clear hist.
//   - PROG: the next SEQ_LEN valid events fill a shadow register. On the last event the pattern register takes the shadow,
//     prog_done pulses at t+1, and the state goes to IDLE.
//   - Timeout or multi event in PROG: error pulse, pattern unchanged, go to IDLE.
//   - prog_req is ignored in OPEN and PROG.
//  KEYPAD_SEQ_PROG_EN undefined:
//   - No prog ports and no PROG state; the pattern is the constant SEQ_PATTERN.
// STRUCTURE
//  keypad_defs.vh: state localparams (IDLE/ENTRY/OPEN/PROG) and a clog2 helper for counter widths.
//  Sub-module key_encoder: press[NUM_KEYS] -> valid, multi, code[KEY_W]. Purely combinational; instanced once.
//  Top: FSM, history shift register, idle and hold counters, output registers.
// TESTING  (NUM_KEYS=4, SEQ_LEN=4, pattern 1,0,1,0, TIMEOUT_CYCLES=16, HOLD_CYCLES=8)
//  1. Press keys 1,0,1,0, 3 cycles apart -> match pulse 1 cycle after the 4th press; unlocked high 8 cycles; then IDLE, progress=0.
//  2. Overlap: keys 1,0,1,1,0,1,0 -> no match through the 6th press; match after the 7th.
//  3. press=4'b0011 mid-entry -> error pulse at t+1, progress=0, the next 1,0,1,0 still matches.
//  4. Keys 1,0 then 16 idle cycles -> error pulse, progress 2->0; presses during OPEN leave progress at 0.
//  5. rst asserted during OPEN cycle 3 -> unlocked=0 and all outputs 0 the next cycle.
//  6. (PROG_EN) prog_req, then keys 2,3,2,3 -> prog_done. Then 2,3,2,3 matches, 1,0,1,0 does not, and rst restores 1,0,1,0.

Source files
------------

// File: rtl/keypad_seq_lock_pkg.sv
// Shared types and helpers for the keypad sequence lock.
// KEYPAD_SEQ_PROG_EN adds the PROG state used for runtime pattern programming.
package keypad_seq_lock_pkg;

`ifdef KEYPAD_SEQ_PROG_EN
  typedef enum logic [1:0] {StIdle, StEntry, StOpen, StProg} state_e;
`else
  typedef enum logic [1:0] {StIdle, StEntry, StOpen} state_e;
`endif

  // Width of a counter that must hold values 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/keypad_seq_lock_if.sv
// Keypad-side and status signals of the sequence lock.
// KEYPAD_SEQ_PROG_EN adds the prog_req / prog_done pair.
interface keypad_seq_lock_if #(
  parameter int unsigned NUM_KEYS = 4,
  parameter int unsigned KEY_W    = 2,
  parameter int unsigned PROG_W   = 3
);
  logic [NUM_KEYS-1:0] press;
  logic                unlocked;
  logic                match;
  logic                error;
  logic [PROG_W-1:0]   progress;
  logic [KEY_W-1:0]    last_key;
`ifdef KEYPAD_SEQ_PROG_EN
  logic                prog_req;
  logic                prog_done;

  modport master (
    output press, prog_req,
    input  unlocked, match, error, progress, last_key, prog_done
  );
  modport slave (
    input  press, prog_req,
    output unlocked, match, error, progress, last_key, prog_done
  );
`else
  modport master (
    output press,
    input  unlocked, match, error, progress, last_key
  );
  modport slave (
    input  press,
    output unlocked, match, error, progress, last_key
  );
`endif
endinterface

// File: rtl/keypad_seq_lock_key_encoder.sv
// Combinational press decoder: one bit set is a valid key, two or more is a multi-press.
module keypad_seq_lock_key_encoder #(
  parameter int unsigned NUM_KEYS = 4,
  parameter int unsigned KEY_W    = 2
) (
  input  logic [NUM_KEYS-1:0] i_press,
  output logic                o_valid,
  output logic                o_multi,
  output logic [KEY_W-1:0]    o_code
);
  logic w_seen;

  always_comb begin
    w_seen  = 1'b0;
    o_multi = 1'b0;
    o_code  = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (i_press[k]) begin
        if (w_seen) o_multi = 1'b1;
        w_seen = 1'b1;
        o_code = KEY_W'(k);
      end
    end
  end

  assign o_valid = w_seen & ~o_multi;
endmodule

// File: rtl/keypad_seq_lock.sv
// Sliding-window keypad combination lock with entry timeout and timed unlock hold.
// Define KEYPAD_SEQ_PROG_EN to make the pattern reprogrammable through prog_req.
module keypad_seq_lock
  import keypad_seq_lock_pkg::*;
#(
  parameter int unsigned                 NUM_KEYS       = 4,
  parameter int unsigned                 SEQ_LEN        = 4,
  parameter int unsigned                 KEY_W          = 2,
  parameter logic [SEQ_LEN*KEY_W-1:0]    SEQ_PATTERN    = 8'b00010001,
  parameter int unsigned                 TIMEOUT_CYCLES = 12_000_000,
  parameter int unsigned                 HOLD_CYCLES    = 36_000_000
) (
  input logic              i_hwclk,
  input logic              i_rst,
  keypad_seq_lock_if.slave io_kp
);
  localparam int unsigned HistW  = SEQ_LEN * KEY_W;
  localparam int unsigned ProgW  = cnt_w(SEQ_LEN);
  localparam int unsigned IdleW  = cnt_w(TIMEOUT_CYCLES - 1);
  localparam int unsigned HoldW  = cnt_w(HOLD_CYCLES - 1);
  localparam logic [ProgW-1:0] FillMax = ProgW'(SEQ_LEN);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES - 1);

  state_e             r_state, w_state_d;
  logic [HistW-1:0]   r_hist, w_hist_d, w_hist_shift, w_pattern;
  logic [ProgW-1:0]   r_fill, w_fill_d, w_fill_inc;
  logic [IdleW-1:0]   r_idle_cnt, w_idle_d;
  logic [HoldW-1:0]   r_hold_cnt, w_hold_d;
  logic [KEY_W-1:0]   r_last_key, w_last_key_d;
  logic               r_match, w_match_d;
  logic               r_error, w_error_d;
  logic               w_valid, w_multi;
  logic [KEY_W-1:0]   w_code;

  keypad_seq_lock_key_encoder #(
    .NUM_KEYS (NUM_KEYS),
    .KEY_W    (KEY_W)
  ) u_key_encoder (
    .i_press (io_kp.press),
    .o_valid (w_valid),
    .o_multi (w_multi),
    .o_code  (w_code)
  );

  // Newest key enters the top element; element 0 ends up holding the oldest.
  assign w_hist_shift = HistW'({w_code, r_hist} >> KEY_W);
  assign w_fill_inc   = (r_fill == FillMax) ? r_fill : r_fill + 1'b1;

`ifdef KEYPAD_SEQ_PROG_EN
  logic [HistW-1:0] r_pattern, w_pattern_d;
  logic             r_prog_done, w_prog_done_d;
  assign w_pattern       = r_pattern;
  assign io_kp.prog_done = r_prog_done;
`else
  assign w_pattern = SEQ_PATTERN;
`endif

  always_comb begin
    w_state_d    = r_state;
    w_hist_d     = r_hist;
    w_fill_d     = r_fill;
    w_idle_d     = r_idle_cnt;
    w_hold_d     = r_hold_cnt;
    w_last_key_d = r_last_key;
    w_match_d    = 1'b0;
    w_error_d    = 1'b0;
`ifdef KEYPAD_SEQ_PROG_EN
    w_pattern_d   = r_pattern;
    w_prog_done_d = 1'b0;
`endif
    unique case (r_state)
      StIdle, StEntry: begin
`ifdef KEYPAD_SEQ_PROG_EN
        if (io_kp.prog_req) begin
          w_state_d = StProg;
          w_hist_d  = '0;
          w_fill_d  = '0;
          w_idle_d  = '0;
        end else
`endif
        if (w_multi) begin
          w_error_d = 1'b1;
          w_state_d = StIdle;
          w_hist_d  = '0;
          w_fill_d  = '0;
          w_idle_d  = '0;
        end else if (w_valid) begin
          w_last_key_d = w_code;
          w_idle_d     = '0;
          if (w_fill_inc == FillMax && w_hist_shift == w_pattern) begin
            w_match_d = 1'b1;
            w_state_d = StOpen;
            w_hist_d  = '0;
            w_fill_d  = '0;
            w_hold_d  = '0;
          end else begin
            w_state_d = StEntry;
            w_hist_d  = w_hist_shift;
            w_fill_d  = w_fill_inc;
          end
        end else if (r_state == StEntry) begin
          if (r_idle_cnt == IdleMax) begin
            w_error_d = 1'b1;
            w_state_d = StIdle;
            w_hist_d  = '0;
            w_fill_d  = '0;
            w_idle_d  = '0;
          end else begin
            w_idle_d = r_idle_cnt + 1'b1;
          end
        end
      end
      StOpen: begin
        if (r_hold_cnt == HoldMax) begin
          w_state_d = StIdle;
          w_hold_d  = '0;
        end else begin
          w_hold_d = r_hold_cnt + 1'b1;
        end
      end
`ifdef KEYPAD_SEQ_PROG_EN
      // r_hist doubles as the shadow register while programming.
      StProg: begin
        if (w_multi || (!w_valid && r_idle_cnt == IdleMax)) begin
          w_error_d = 1'b1;
          w_state_d = StIdle;
          w_hist_d  = '0;
          w_fill_d  = '0;
          w_idle_d  = '0;
        end else if (w_valid) begin
          w_last_key_d = w_code;
          w_idle_d     = '0;
          if (w_fill_inc == FillMax) begin
            w_pattern_d   = w_hist_shift;
            w_prog_done_d = 1'b1;
            w_state_d     = StIdle;
            w_hist_d      = '0;
            w_fill_d      = '0;
          end else begin
            w_hist_d = w_hist_shift;
            w_fill_d = w_fill_inc;
          end
        end else begin
          w_idle_d = r_idle_cnt + 1'b1;
        end
      end
`endif
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_hwclk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_hist     <= '0;
      r_fill     <= '0;
      r_idle_cnt <= '0;
      r_hold_cnt <= '0;
      r_last_key <= '0;
      r_match    <= 1'b0;
      r_error    <= 1'b0;
`ifdef KEYPAD_SEQ_PROG_EN
      r_pattern   <= SEQ_PATTERN;
      r_prog_done <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_hist     <= w_hist_d;
      r_fill     <= w_fill_d;
      r_idle_cnt <= w_idle_d;
      r_hold_cnt <= w_hold_d;
      r_last_key <= w_last_key_d;
      r_match    <= w_match_d;
      r_error    <= w_error_d;
`ifdef KEYPAD_SEQ_PROG_EN
      r_pattern   <= w_pattern_d;
      r_prog_done <= w_prog_done_d;
`endif
    end
  end

  assign io_kp.unlocked = (r_state == StOpen);
  assign io_kp.match    = r_match;
  assign io_kp.error    = r_error;
  assign io_kp.progress = r_fill;
  assign io_kp.last_key = r_last_key;
endmodule
